// File: rtl/mig_app_responder.sv
// mig_app_responder
//
// Memory-controller side of the MIG 7-series user (app) interface. Used in
// place of mig_7series_0 for simulation and loopback bring-up builds.
// After a calibration delay it accepts commands and write data into two
// small FIFOs. It executes one command per cycle, in order, against an
// internal word array, and returns read data after a fixed latency.
// app_rdy can be forced low periodically to exercise backpressure.
//
// Ports
//   ui_clk, ui_clk_sync_rst        clock, synchronous active-high reset
//   app_addr/app_cmd/app_en        command channel (000 write, 001 read)
//   app_rdy                        command accepted on app_en & app_rdy
//   app_wdf_data/mask/wren/end     single-beat write-data channel
//   app_wdf_rdy                    data accepted on app_wdf_wren & app_wdf_rdy
//   app_rd_data/valid/end          read return, no backpressure
//   init_calib_complete            sticky, rises CALIB_CYCLES after reset
//   cmd_err                        sticky protocol-error flag
//
// Handshake: a transfer happens on a ui_clk edge where valid (app_en or
// app_wdf_wren) and ready (app_rdy or app_wdf_rdy) are both high. Both
// ready signals depend only on registered state, never on valid.
//
// Assumptions: CMD_DEPTH and WDF_DEPTH are powers of two >= 2,
// MASK_WIDTH == DATA_WIDTH/8, ADDR_WIDTH > DEPTH_LOG2+3, and CALIB_CYCLES
// and RD_LATENCY are >= 1.
module mig_app_responder #(
    parameter int ADDR_WIDTH   = 29,
    parameter int DATA_WIDTH   = 256,
    parameter int MASK_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 6,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int STALL_PERIOD = 7
) (
    input  logic                  ui_clk,
    input  logic                  ui_clk_sync_rst,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    output logic                  app_rdy,
    input  logic [DATA_WIDTH-1:0] app_wdf_data,
    input  logic [MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                  app_wdf_wren,
    input  logic                  app_wdf_end,
    output logic                  app_wdf_rdy,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_data_valid,
    output logic                  app_rd_data_end,
    output logic                  init_calib_complete,
    output logic                  cmd_err
);

    localparam int NWORDS = 1 << DEPTH_LOG2;
    localparam int CP_W   = $clog2(CMD_DEPTH);
    localparam int CC_W   = $clog2(CMD_DEPTH + 1);
    localparam int WP_W   = $clog2(WDF_DEPTH);
    localparam int WC_W   = $clog2(WDF_DEPTH + 1);
    localparam int CAL_W  = $clog2(CALIB_CYCLES) + 1;
    localparam int ST_W   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    // ---------------- state ----------------
    logic [CAL_W-1:0]      r_calib_cnt;
    logic                  r_calib;
    logic [ST_W-1:0]       r_stall_cnt;
    logic                  r_cmd_err;

    logic                  r_cmd_rd  [CMD_DEPTH];
    logic [DEPTH_LOG2-1:0] r_cmd_idx [CMD_DEPTH];
    logic [CP_W-1:0]       r_cmd_wp;
    logic [CP_W-1:0]       r_cmd_rp;
    logic [CC_W-1:0]       r_cmd_cnt;

    logic [DATA_WIDTH-1:0] r_wdf_data [WDF_DEPTH];
    logic [MASK_WIDTH-1:0] r_wdf_mask [WDF_DEPTH];
    logic [WP_W-1:0]       r_wdf_wp;
    logic [WP_W-1:0]       r_wdf_rp;
    logic [WC_W-1:0]       r_wdf_cnt;

    logic [DATA_WIDTH-1:0] r_mem [NWORDS];

    logic [RD_LATENCY-1:0] r_pv;
    logic [DATA_WIDTH-1:0] r_pd [RD_LATENCY];

    // ---------------- combinational ----------------
    logic                  w_stall;
    logic                  w_cmd_full;
    logic                  w_wdf_full;
    logic                  w_cmd_legal;
    logic                  w_cmd_acc;
    logic                  w_cmd_push;
    logic                  w_wdf_push;
    logic                  w_head_rd;
    logic [DEPTH_LOG2-1:0] w_head_idx;
    logic                  w_exec_rd;
    logic                  w_exec_wr;
    logic                  w_cmd_pop;
    logic                  w_err_set;
    logic [DEPTH_LOG2-1:0] w_in_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [MASK_WIDTH-1:0] w_head_mask;
    logic                  w_unused_addr;

    // Upper address bits alias onto the stored words.
    assign w_unused_addr = &{1'b0, app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3]};
    assign w_in_idx      = app_addr[3 +: DEPTH_LOG2];

    assign w_stall    = (STALL_PERIOD != 0) && (r_stall_cnt == ST_W'(STALL_PERIOD - 1));
    assign w_cmd_full = (r_cmd_cnt == CC_W'(CMD_DEPTH));
    assign w_wdf_full = (r_wdf_cnt == WC_W'(WDF_DEPTH));

    assign app_rdy     = r_calib & ~w_stall & ~w_cmd_full;
    assign app_wdf_rdy = r_calib & ~w_wdf_full;

    assign w_cmd_legal = (app_cmd == 3'b000) || (app_cmd == 3'b001);
    assign w_cmd_acc   = app_en & app_rdy;
    assign w_cmd_push  = w_cmd_acc & w_cmd_legal;
    assign w_wdf_push  = app_wdf_wren & app_wdf_rdy;

    // Only entries present at the start of the cycle can execute, so a
    // command never executes in the cycle it is accepted.
    assign w_head_rd   = r_cmd_rd[r_cmd_rp];
    assign w_head_idx  = r_cmd_idx[r_cmd_rp];
    assign w_head_data = r_wdf_data[r_wdf_rp];
    assign w_head_mask = r_wdf_mask[r_wdf_rp];
    assign w_exec_rd   = (r_cmd_cnt != '0) & w_head_rd;
    assign w_exec_wr   = (r_cmd_cnt != '0) & ~w_head_rd & (r_wdf_cnt != '0);
    assign w_cmd_pop   = w_exec_rd | w_exec_wr;
    assign w_rd_word   = r_mem[w_head_idx];

    assign w_err_set = (w_cmd_acc & ~w_cmd_legal)
                     | (w_cmd_push & (app_addr[2:0] != 3'b000))
                     | (app_wdf_end != app_wdf_wren)
                     | (~r_calib & (app_en | app_wdf_wren));

    // ---------------- calibration, stall, error ----------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_calib_cnt <= '0;
            r_calib     <= 1'b0;
            r_stall_cnt <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            if (!r_calib) begin
                if (r_calib_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                    r_calib <= 1'b1;
                end else begin
                    r_calib_cnt <= r_calib_cnt + CAL_W'(1);
                end
            end
            // The stall phase starts at 0 in the first calibrated cycle.
            if (r_calib && (STALL_PERIOD != 0)) begin
                if (w_stall) begin
                    r_stall_cnt <= '0;
                end else begin
                    r_stall_cnt <= r_stall_cnt + ST_W'(1);
                end
            end
            r_cmd_err <= r_cmd_err | w_err_set;
        end
    end

    // ---------------- command FIFO ----------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_cmd_cnt <= '0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_wp <= r_cmd_wp + CP_W'(1);
            end
            if (w_cmd_pop) begin
                r_cmd_rp <= r_cmd_rp + CP_W'(1);
            end
            if (w_cmd_push && !w_cmd_pop) begin
                r_cmd_cnt <= r_cmd_cnt + CC_W'(1);
            end else if (!w_cmd_push && w_cmd_pop) begin
                r_cmd_cnt <= r_cmd_cnt - CC_W'(1);
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (w_cmd_push) begin
            r_cmd_rd[r_cmd_wp]  <= app_cmd[0];
            r_cmd_idx[r_cmd_wp] <= w_in_idx;
        end
    end

    // ---------------- write-data FIFO ----------------
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_wdf_wp  <= '0;
            r_wdf_rp  <= '0;
            r_wdf_cnt <= '0;
        end else begin
            if (w_wdf_push) begin
                r_wdf_wp <= r_wdf_wp + WP_W'(1);
            end
            if (w_exec_wr) begin
                r_wdf_rp <= r_wdf_rp + WP_W'(1);
            end
            if (w_wdf_push && !w_exec_wr) begin
                r_wdf_cnt <= r_wdf_cnt + WC_W'(1);
            end else if (!w_wdf_push && w_exec_wr) begin
                r_wdf_cnt <= r_wdf_cnt - WC_W'(1);
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (w_wdf_push) begin
            r_wdf_data[r_wdf_wp] <= app_wdf_data;
            r_wdf_mask[r_wdf_wp] <= app_wdf_mask;
        end
    end

    // ---------------- word array ----------------
    // Contents survive reset; a write pending at the reset edge is dropped.
    always_ff @(posedge ui_clk) begin
        if (w_exec_wr && !ui_clk_sync_rst) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!w_head_mask[b]) begin
                    r_mem[w_head_idx][8*b +: 8] <= w_head_data[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    // Each stage only loads data alongside a valid, so the last stage
    // holds the most recent read word between beats.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_exec_rd;
            if (w_exec_rd) begin
                r_pd[0] <= w_rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    assign app_rd_data         = r_pd[RD_LATENCY-1];
    assign app_rd_data_valid   = r_pv[RD_LATENCY-1];
    assign app_rd_data_end     = r_pv[RD_LATENCY-1];
    assign init_calib_complete = r_calib;
    assign cmd_err             = r_cmd_err;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder. Two instances share all inputs:
// u_dut0 has stalls disabled and carries the data-path checks, while u_dut7
// uses the default stall period and carries the backpressure checks.
module tb_mig_app_responder;

    logic         clk;
    logic         rst;
    logic [28:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;

    logic         app_rdy_0, app_wdf_rdy_0, rd_valid_0, rd_end_0, calib_0, cmd_err_0;
    logic [255:0] rd_data_0;
    logic         app_rdy_7, app_wdf_rdy_7, rd_valid_7, rd_end_7, calib_7, cmd_err_7;
    logic [255:0] rd_data_7;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] D3    = {8{32'h1234_5678}};
    localparam logic [255:0] D6    = {8{32'hCAFE_F00D}};
    localparam logic [255:0] ONES  = {256{1'b1}};
    localparam logic [255:0] MASKD = {{28{8'hFF}}, 32'h0000_0000};

    mig_app_responder #(.STALL_PERIOD(0)) u_dut0 (
        .ui_clk(clk), .ui_clk_sync_rst(rst),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy_0),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy_0),
        .app_rd_data(rd_data_0), .app_rd_data_valid(rd_valid_0), .app_rd_data_end(rd_end_0),
        .init_calib_complete(calib_0), .cmd_err(cmd_err_0)
    );

    mig_app_responder u_dut7 (
        .ui_clk(clk), .ui_clk_sync_rst(rst),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy_7),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy_7),
        .app_rd_data(rd_data_7), .app_rd_data_valid(rd_valid_7), .app_rd_data_end(rd_end_7),
        .init_calib_complete(calib_7), .cmd_err(cmd_err_7)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [28:0] addr, input logic [255:0] data,
                            input logic [31:0] mask);
        int n = 0;
        while (!(app_rdy_0 && app_wdf_rdy_0) && n < 20) begin
            step;
            n++;
        end
        chk("wr_ready", {255'd0, app_rdy_0 & app_wdf_rdy_0}, 256'd1);
        app_en = 1'b1; app_cmd = 3'b000; app_addr = addr;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = data; app_wdf_mask = mask;
        step;
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    // Issue one read into an idle responder and check data and latency.
    task automatic read_check(input string tag, input logic [28:0] addr,
                              input logic [255:0] exp);
        int n = 0;
        chk({tag, "_rdy"}, {255'd0, app_rdy_0}, 256'd1);
        app_en = 1'b1; app_cmd = 3'b001; app_addr = addr;
        step;
        app_en = 1'b0;
        n = 1;
        while (!rd_valid_0 && n < 20) begin
            step;
            n++;
        end
        chk({tag, "_valid"}, {255'd0, rd_valid_0}, 256'd1);
        chk({tag, "_data"}, rd_data_0, exp);
        chk({tag, "_lat"}, 256'(n), 256'd5);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int got;
        int first;
        int last;
        int nv;
        int n;

        rst = 1'b1; app_addr = '0; app_cmd = '0; app_en = 1'b0;
        app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        step;
        do_reset;

        // Reset state and calibration delay.
        chk("rst_calib", {255'd0, calib_0}, 256'd0);
        chk("rst_rdy", {255'd0, app_rdy_0}, 256'd0);
        chk("rst_wdf_rdy", {255'd0, app_wdf_rdy_0}, 256'd0);
        chk("rst_valid", {255'd0, rd_valid_0}, 256'd0);
        chk("rst_data", rd_data_0, 256'd0);
        chk("rst_err", {255'd0, cmd_err_0}, 256'd0);
        repeat (15) step;
        chk("calib_15", {255'd0, calib_0}, 256'd0);
        chk("rdy_15", {255'd0, app_rdy_0}, 256'd0);
        step;
        chk("calib_16", {255'd0, calib_0}, 256'd1);
        chk("rdy_16", {255'd0, app_rdy_0}, 256'd1);
        chk("wdf_rdy_16", {255'd0, app_wdf_rdy_0}, 256'd1);
        chk("calib7_16", {255'd0, calib_7}, 256'd1);
        chk("rdy7_16", {255'd0, app_rdy_7}, 256'd1);

        // Write 2,4,...,20 to words 0..9, then read them back-to-back.
        for (int i = 0; i < 10; i++) begin
            do_write(29'(8 * i), 256'(2 * (i + 1)), 32'h0);
        end
        got = 0; first = 0; last = 0;
        for (int k = 0; k < 40 && got < 10; k++) begin
            if (k < 10) begin
                chk("burst_rdy", {255'd0, app_rdy_0}, 256'd1);
                app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'(8 * k);
            end else begin
                app_en = 1'b0;
            end
            step;
            if (rd_valid_0) begin
                if (got == 0) first = k + 1;
                last = k + 1;
                chk("burst_data", rd_data_0, 256'(2 * (got + 1)));
                chk("burst_end", {255'd0, rd_end_0}, 256'd1);
                got++;
            end
        end
        app_en = 1'b0;
        chk("burst_beats", 256'(got), 256'd10);
        chk("burst_first", 256'(first), 256'd5);
        chk("burst_last", 256'(last), 256'd14);

        // Write data arrives 3 cycles after its command; a read is queued behind.
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 29'd80;
        step;
        app_cmd = 3'b001;
        step;
        app_en = 1'b0;
        step;
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = D3; app_wdf_mask = 32'h0;
        step;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        n = 0;
        while (!rd_valid_0 && n < 20) begin
            step;
            n++;
        end
        chk("late_valid", {255'd0, rd_valid_0}, 256'd1);
        chk("late_data", rd_data_0, D3);
        chk("late_err", {255'd0, cmd_err_0}, 256'd0);
        step;
        chk("hold_valid", {255'd0, rd_valid_0}, 256'd0);
        chk("hold_data", rd_data_0, D3);

        // Byte mask: low 4 bytes keep the old zeros.
        do_write(29'd88, 256'd0, 32'h0);
        do_write(29'd88, ONES, 32'h0000_000F);
        read_check("mask", 29'd88, MASKD);
        chk("mask_err", {255'd0, cmd_err_0}, 256'd0);

        // Misaligned address flags an error but still writes word 0.
        do_write(29'd4, D6, 32'h0);
        chk("misalign_err", {255'd0, cmd_err_0}, 256'd1);
        read_check("misalign", 29'd0, D6);

        // Illegal command is dropped; array contents survive reset.
        do_reset;
        chk("rst2_err", {255'd0, cmd_err_0}, 256'd0);
        repeat (16) step;
        app_en = 1'b1; app_cmd = 3'b010; app_addr = 29'd8;
        step;
        app_en = 1'b0;
        chk("badcmd_err", {255'd0, cmd_err_0}, 256'd1);
        read_check("after_bad", 29'd8, 256'd4);

        // Reset in the middle of a read burst.
        for (int k = 0; k < 6; k++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'(8 * k);
            step;
            if (k == 4) begin
                chk("mid_valid", {255'd0, rd_valid_0}, 256'd1);
                chk("mid_data", rd_data_0, D6);
            end
        end
        app_en = 1'b0;
        do_reset;
        chk("midrst_valid", {255'd0, rd_valid_0}, 256'd0);
        chk("midrst_data", rd_data_0, 256'd0);
        chk("midrst_err", {255'd0, cmd_err_0}, 256'd0);
        chk("midrst_calib", {255'd0, calib_0}, 256'd0);
        nv = 0;
        for (int k = 0; k < 25; k++) begin
            step;
            if (rd_valid_0) nv++;
        end
        chk("stale_beats", 256'(nv), 256'd0);

        // Command during calibration is ignored and flagged.
        do_reset;
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'd0;
        chk("precal_rdy", {255'd0, app_rdy_0}, 256'd0);
        step;
        app_en = 1'b0;
        chk("precal_err", {255'd0, cmd_err_0}, 256'd1);

        // app_wdf_end without app_wdf_wren.
        do_reset;
        repeat (16) step;
        chk("wdfend_pre", {255'd0, cmd_err_0}, 256'd0);
        app_wdf_end = 1'b1;
        step;
        app_wdf_end = 1'b0;
        chk("wdfend_err", {255'd0, cmd_err_0}, 256'd1);

        // Periodic stall on u_dut7 with continuous reads.
        do_reset;
        repeat (16) step;
        for (int j = 0; j < 14; j++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = 29'd0;
            chk("stall_rdy", {255'd0, app_rdy_7}, 256'(j % 7 != 6));
            step;
        end
        app_en = 1'b0;
        repeat (3) step;

        // Writes without data fill the command FIFO and hold app_rdy low.
        app_en = 1'b1; app_cmd = 3'b000; app_addr = 29'd16;
        repeat (10) step;
        app_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk("full_rdy", {255'd0, app_rdy_7}, 256'd0);
            step;
        end
        chk("full_wdf_rdy", {255'd0, app_wdf_rdy_7}, 256'd1);
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = D3; app_wdf_mask = 32'h0;
        step;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        chk("drain_rdy_early", {255'd0, app_rdy_7}, 256'd0);
        n = 0;
        while (!app_rdy_7 && n < 4) begin
            step;
            n++;
        end
        chk("drain_rdy", {255'd0, app_rdy_7}, 256'd1);
        app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
        repeat (3) step;
        app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
        repeat (6) step;
        chk("stall_err", {255'd0, cmd_err_7}, 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
